// File: rtl/fifo_rd_prefetch_pkg.sv
// Shared defaults and pointer helper for the FIFO read prefetch front-end.
package fifo_rd_prefetch_pkg;

    localparam int DATA_WIDTH_DEFAULT  = 8;
    localparam int FIFO_PREFETCH_DEPTH = 3;

    // Circular increment for buffer pointers whose depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_prefetch_buf.sv
// Prefetch storage: register array written at wr_ptr, read asynchronously at rd_ptr.
module fifo_rd_prefetch_buf
    import fifo_rd_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = FIFO_PREFETCH_DEPTH,
    parameter int PTR_WIDTH  = $clog2(BUF_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [PTR_WIDTH-1:0]  i_wr_ptr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [PTR_WIDTH-1:0]  i_rd_ptr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];

    // Data storage carries no reset; occupancy is tracked by the control logic.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

// File: rtl/fifo_rd_prefetch.sv
// First-word-fall-through read front-end: credit-managed prefetch from a sync FIFO core.
module fifo_rd_prefetch
    import fifo_rd_prefetch_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int BUF_DEPTH  = FIFO_PREFETCH_DEPTH,
    parameter int PTR_WIDTH  = $clog2(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  rd_ready,
    input  logic                  rd_empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [PTR_WIDTH:0]    buf_count
);

    localparam int CNT_W  = PTR_WIDTH + 1;
    localparam int CRED_W = CNT_W + 1;
    localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(BUF_DEPTH);

    logic                  r_rd_ready;
    logic                  r_inflight;
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    logic                  w_accept;
    logic                  w_write;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_next_count;
    logic [CRED_W-1:0]     w_next_credit;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_accept = r_rd_ready & ~rd_empty;
    assign w_write  = r_inflight;
    assign w_pop    = dout_valid & dout_ready;

    // Credit looks at next-cycle occupancy so rd_ready never depends on dout_ready combinationally.
    always_comb begin
        w_next_count = r_count;
        if (w_write && !w_pop) begin
            w_next_count = r_count + CNT_W'(1);
        end else if (!w_write && w_pop) begin
            w_next_count = r_count - CNT_W'(1);
        end
        w_next_credit = {1'b0, w_next_count} + {{CNT_W{1'b0}}, w_accept};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ready <= 1'b0;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= w_accept;
            r_count    <= w_next_count;
            r_rd_ready <= (w_next_credit < DEPTH_C);
            if (w_write) begin
                r_wr_ptr <= PTR_WIDTH'(wrap_inc(32'(r_wr_ptr), BUF_DEPTH));
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_WIDTH'(wrap_inc(32'(r_rd_ptr), BUF_DEPTH));
            end
        end
    end

    fifo_rd_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_prefetch_buf (
        .i_clk     (clk),
        .i_wr_en   (w_write),
        .i_wr_ptr  (r_wr_ptr),
        .i_wr_data (rd_data),
        .i_rd_ptr  (r_rd_ptr),
        .o_rd_data (w_head)
    );

    // Head is masked while empty so dout reads zero out of reset.
    assign dout_valid = (r_count != '0);
    assign dout       = dout_valid ? w_head : '0;
    assign buf_count  = r_count;
    assign rd_ready   = r_rd_ready;

endmodule
